serialize_result_reg_hd: RTL and testbench

//  Output-side counterpart of the digit-gathering input buffer. Takes one group of Num_bits

---
 rtl/serialize_result_reg_hd_pkg.sv | 22 ++
 rtl/serialize_result_reg_hd_if.sv | 31 +++
 rtl/serialize_result_reg_hd_digit_group_fifo.sv | 76 +++++++
 rtl/serialize_result_reg_hd.sv | 130 +++++++++++++
 tb/tb_serialize_result_reg_hd.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serialize_result_reg_hd_pkg.sv
// Shared types and constants for the signed-digit result serializer.
// Digit codes are {plus, minus}; code 2'b11 is never produced and is passed through untouched.
package serialize_result_reg_hd_pkg;

  localparam int NUM_BITS       = 4;
  localparam int RAM_ADDR_WIDTH = 7;
  localparam int FIFO_DEPTH     = 4;
  localparam int DIGIT_W        = $clog2(NUM_BITS);
  localparam int CNT_W          = RAM_ADDR_WIDTH + DIGIT_W;
  localparam int GROUP_W        = 2 * NUM_BITS;

  localparam logic [1:0] DIG_ZERO = 2'b00;
  localparam logic [1:0] DIG_POS  = 2'b10;
  localparam logic [1:0] DIG_NEG  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serialize_result_reg_hd_if.sv
// Control, group-input and digit-output signals of the serializer.
// Handshakes: a transfer happens in a cycle where valid & ready & enable_all are all high;
// the sender holds valid and data stable until that cycle, ready never depends on valid.
interface serialize_result_reg_hd_if;
  import serialize_result_reg_hd_pkg::*;

  logic                      enable_all;
  logic                      start;
  logic [RAM_ADDR_WIDTH-1:0] last_cycle;
  logic                      in_valid;
  logic                      in_ready;
  logic [NUM_BITS-1:0]       z_plus;
  logic [NUM_BITS-1:0]       z_minus;
  logic                      out_valid;
  logic                      out_ready;
  logic [1:0]                z_value;
  logic [CNT_W-1:0]          out_cnt;
  logic                      out_last;
  logic                      done;

  modport master (
    output enable_all, start, last_cycle, in_valid, z_plus, z_minus, out_ready,
    input  in_ready, out_valid, z_value, out_cnt, out_last, done
  );

  modport slave (
    input  enable_all, start, last_cycle, in_valid, z_plus, z_minus, out_ready,
    output in_ready, out_valid, z_value, out_cnt, out_last, done
  );

endinterface

// File: rtl/serialize_result_reg_hd_digit_group_fifo.sv
// Synchronous FIFO of digit groups with flush; full/empty are registered so that
// ready logic built on them has no combinational path from the write side.
module digit_group_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push_ok, pop_ok;

  assign push_ok = push_i & ~full_q;
  assign pop_ok  = pop_i & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
    full_d  = (count_d == (AW+1)'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/serialize_result_reg_hd.sv
// Buffers signed-digit result groups and streams them out one digit per clock, MSB first.
// A shift register holds the group on the output; the FIFO holds the groups queued behind it.
module serialize_result_reg_hd
  import serialize_result_reg_hd_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  serialize_result_reg_hd_if.slave     bus,
  output state_e                       dbg_state_o
);

  state_e                    state_q, state_d;
  logic [NUM_BITS-1:0]       plus_q, plus_d;
  logic [NUM_BITS-1:0]       minus_q, minus_d;
  logic                      sr_valid_q, sr_valid_d;
  logic [CNT_W-1:0]          out_cnt_q, out_cnt_d;
  logic [RAM_ADDR_WIDTH:0]   groups_in_q, groups_in_d;
  logic [RAM_ADDR_WIDTH-1:0] last_q, last_d;

  logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [GROUP_W-1:0] fifo_rdata;

  logic run, start_go, in_ready, accept, take, digit_last, out_last;
  logic need_load, load_fifo, load_bypass;

  assign run        = (state_q == ST_RUN);
  assign start_go   = bus.enable_all & bus.start & (state_q == ST_IDLE);
  assign in_ready   = bus.enable_all & run & ~fifo_full & (groups_in_q <= {1'b0, last_q});
  assign accept     = bus.in_valid & in_ready;
  assign take       = sr_valid_q & bus.out_ready & bus.enable_all;
  assign digit_last = (out_cnt_q[DIGIT_W-1:0] == DIGIT_W'(NUM_BITS - 1));
  assign out_last   = sr_valid_q & (out_cnt_q[CNT_W-1:DIGIT_W] == last_q) & digit_last;

  // An empty pipe takes the incoming group straight into the shift register,
  // which is what gives the one-cycle accept-to-valid latency.
  assign need_load   = bus.enable_all & run & (~sr_valid_q | (take & digit_last));
  assign load_fifo   = need_load & ~fifo_empty;
  assign load_bypass = need_load & fifo_empty & accept;
  assign fifo_push   = accept & ~load_bypass;
  assign fifo_pop    = load_fifo;

  digit_group_fifo #(
    .WIDTH (GROUP_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (start_go),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i ({bus.z_plus, bus.z_minus}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_go) state_d = ST_RUN;
      ST_RUN:  if (take && out_last) state_d = ST_DONE;
      ST_DONE: if (bus.enable_all) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    plus_d      = plus_q;
    minus_d     = minus_q;
    sr_valid_d  = sr_valid_q;
    out_cnt_d   = out_cnt_q;
    groups_in_d = groups_in_q;
    last_d      = last_q;
    if (start_go) begin
      plus_d      = '0;
      minus_d     = '0;
      sr_valid_d  = 1'b0;
      out_cnt_d   = '0;
      groups_in_d = '0;
      last_d      = bus.last_cycle;
    end else begin
      if (take)   out_cnt_d   = out_cnt_q + CNT_W'(1);
      if (accept) groups_in_d = groups_in_q + (RAM_ADDR_WIDTH+1)'(1);
      if (need_load) begin
        if (load_fifo) begin
          {plus_d, minus_d} = fifo_rdata;
          sr_valid_d        = 1'b1;
        end else if (load_bypass) begin
          plus_d     = bus.z_plus;
          minus_d    = bus.z_minus;
          sr_valid_d = 1'b1;
        end else begin
          sr_valid_d = 1'b0;
        end
      end else if (take) begin
        plus_d  = {plus_q[NUM_BITS-2:0], 1'b0};
        minus_d = {minus_q[NUM_BITS-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      plus_q      <= '0;
      minus_q     <= '0;
      sr_valid_q  <= 1'b0;
      out_cnt_q   <= '0;
      groups_in_q <= '0;
      last_q      <= '0;
    end else begin
      state_q     <= state_d;
      plus_q      <= plus_d;
      minus_q     <= minus_d;
      sr_valid_q  <= sr_valid_d;
      out_cnt_q   <= out_cnt_d;
      groups_in_q <= groups_in_d;
      last_q      <= last_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = sr_valid_q;
  assign bus.z_value   = {plus_q[NUM_BITS-1], minus_q[NUM_BITS-1]};
  assign bus.out_cnt   = out_cnt_q;
  assign bus.out_last  = out_last;
  assign bus.done      = (state_q == ST_DONE);
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_serialize_result_reg_hd.sv
// Bench for serialize_result_reg_hd: groups accepted on the input are expanded into
// expected digits {value, index, last}; a monitor checks every output cycle against them.
module tb_serialize_result_reg_hd;
  import serialize_result_reg_hd_pkg::*;

  localparam int EW = 2 + CNT_W + 1;

  logic   clk;
  logic   rst_n;
  state_e dbg_state;

  serialize_result_reg_hd_if bus();

  serialize_result_reg_hd dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [EW-1:0] exp_q[$];
  bit running   = 0;
  bit done_exp  = 0;
  bit done_seen = 0;
  bit abort_prod = 0;
  int acc_cnt = 0;
  int last_m  = 0;
  int rdy_pct = 100;
  int en_pct  = 100;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic rand_group(output logic [NUM_BITS-1:0] p, output logic [NUM_BITS-1:0] m);
    logic [1:0] d;
    for (int i = 0; i < NUM_BITS; i++) begin
      case ($urandom_range(2))
        0:       d = DIG_ZERO;
        1:       d = DIG_POS;
        default: d = DIG_NEG;
      endcase
      p[i] = d[1];
      m[i] = d[0];
    end
  endtask

  // driver tasks
  task automatic start_op(input int last);
    done_seen = 0;
    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.last_cycle = RAM_ADDR_WIDTH'(last);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.enable_all) break;
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic produce(input int n, input bit fixed, input logic [NUM_BITS-1:0] fp,
                         input logic [NUM_BITS-1:0] fm, input int gap_pct);
    logic [NUM_BITS-1:0] p, m;
    bit acc;
    int w;
    for (int g = 0; g < n && !abort_prod; g++) begin
      if (fixed) begin
        p = fp;
        m = fm;
      end else begin
        rand_group(p, m);
      end
      if ($urandom_range(99) < gap_pct) begin
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.z_plus   = p;
      bus.z_minus  = m;
      acc = 0;
      w   = 0;
      while (!acc && w < 300 && !abort_prod) begin
        @(negedge clk);
        acc = rst_n && bus.in_valid && bus.in_ready && bus.enable_all;
        w++;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    for (int c = 0; c < bound && !done_seen; c++) @(posedge clk);
    chk("op_complete", 32'(done_seen), 32'(1));
  endtask

  task automatic check_reset_outputs();
    chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_z_value",   32'(bus.z_value),   32'(0));
    chk("rst_out_cnt",   32'(bus.out_cnt),   32'(0));
    chk("rst_out_last",  32'(bus.out_last),  32'(0));
    chk("rst_done",      32'(bus.done),      32'(0));
    chk("rst_in_ready",  32'(bus.in_ready),  32'(0));
    chk("rst_state",     32'(dbg_state),     32'(ST_IDLE));
  endtask

  // consumer ready and global enable
  initial begin
    bus.out_ready  = 1'b0;
    bus.enable_all = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.out_ready  = ($urandom_range(99) < rdy_pct);
      bus.enable_all = ($urandom_range(99) < en_pct);
    end
  end

  // scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        running  = 0;
        done_exp = 0;
        acc_cnt  = 0;
      end else begin
        bit            run0, was_done, exp_rdy;
        int            pending;
        logic [EW-1:0] head, ent;
        logic [1:0]    val;
        run0     = running;
        was_done = done_exp;
        chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0 && bus.out_valid) begin
          head = exp_q[0];
          chk("z_value",  32'(bus.z_value),  32'(head[EW-1 -: 2]));
          chk("out_cnt",  32'(bus.out_cnt),  32'(head[CNT_W:1]));
          chk("out_last", 32'(bus.out_last), 32'(head[0]));
        end
        chk("done", 32'(bus.done), 32'(done_exp));
        pending = (exp_q.size() + NUM_BITS - 1) / NUM_BITS;
        exp_rdy = running && bus.enable_all && (pending < FIFO_DEPTH + 1) && (acc_cnt <= last_m);
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        if (done_exp && bus.enable_all) begin
          done_exp  = 0;
          done_seen = 1;
        end
        if (bus.out_valid && bus.out_ready && bus.enable_all && exp_q.size() != 0) begin
          head = exp_q.pop_front();
          if (head[0]) begin
            running  = 0;
            done_exp = 1;
          end
        end
        if (bus.in_valid && bus.in_ready && bus.enable_all) begin
          for (int k = 0; k < NUM_BITS; k++) begin
            val = {bus.z_plus[NUM_BITS-1-k], bus.z_minus[NUM_BITS-1-k]};
            ent = {val, CNT_W'(acc_cnt * NUM_BITS + k),
                   (acc_cnt == last_m) && (k == NUM_BITS - 1)};
            exp_q.push_back(ent);
          end
          acc_cnt++;
        end
        if (bus.start && bus.enable_all && !run0 && !was_done) begin
          running = 1;
          acc_cnt = 0;
          last_m  = int'(bus.last_cycle);
          exp_q.delete();
        end
      end
    end
  end

  // stimulus sequence
  initial begin
    int last;
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.last_cycle = '0;
    bus.in_valid   = 1'b0;
    bus.z_plus     = '0;
    bus.z_minus    = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    #2 rst_n = 1'b1;

    // single group, fixed digits 10,00,00,01
    start_op(0);
    fork
      produce(1, 1, 4'b1000, 4'b0001, 0);
      wait_done(200);
    join
    repeat (2) @(posedge clk);

    // four groups back to back
    start_op(3);
    fork
      produce(4, 0, '0, '0, 0);
      wait_done(300);
    join

    // consumer stalled while the producer fills the pipe
    rdy_pct = 0;
    start_op(7);
    fork
      produce(8, 0, '0, '0, 0);
      begin
        repeat (20) @(posedge clk);
        rdy_pct = 100;
        wait_done(500);
      end
    join

    // global enable dropped mid-stream
    start_op(5);
    fork
      produce(6, 0, '0, '0, 0);
      begin
        repeat (8) @(posedge clk);
        en_pct = 0;
        repeat (3) @(posedge clk);
        en_pct = 100;
        wait_done(500);
      end
    join

    // extra group past last_cycle and a start pulse while running
    start_op(2);
    fork
      produce(4, 0, '0, '0, 0);
      begin
        repeat (4) @(posedge clk);
        #1;
        bus.start      = 1'b1;
        bus.last_cycle = '0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(800);
      end
    join

    // asynchronous reset mid-operand, then a fresh operand
    start_op(3);
    fork
      produce(4, 0, '0, '0, 0);
      begin
        repeat (6) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_reset_outputs();
        abort_prod = 1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
      end
    join
    abort_prod = 0;
    start_op(1);
    fork
      produce(2, 0, '0, '0, 0);
      wait_done(300);
    join

    // randomized operands with random backpressure and enable
    for (int r = 0; r < 6; r++) begin
      last    = $urandom_range(0, 9);
      rdy_pct = $urandom_range(30, 100);
      en_pct  = $urandom_range(70, 100);
      start_op(last);
      fork
        produce(last + 1, 0, '0, '0, 30);
        wait_done(3000);
      join
      rdy_pct = 100;
      en_pct  = 100;
      repeat (2) @(posedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
